// File: rtl/mul_pipe_param.sv
// Parametrised pipelined integer multiplier with valid/ready retirement, flush
// and a decode-side hazard query over every in-flight destination register.
module mul_pipe_param #(
  parameter int WIDTH    = 32,
  parameter int STAGES   = 5,
  parameter int REG_ADDR = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_signed,
  input  logic [WIDTH-1:0]             src1,
  input  logic [WIDTH-1:0]             src2,
  input  logic [REG_ADDR-1:0]          in_wreg,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_result,
  output logic [REG_ADDR-1:0]          out_wreg,
  output logic                         out_zero,
  output logic                         out_overflow,
  input  logic [REG_ADDR-1:0]          qreg1,
  input  logic [REG_ADDR-1:0]          qreg2,
  output logic                         hit1,
  output logic                         hit2,
  output logic [$clog2(STAGES+1)-1:0]  pending
);

  localparam int PW = $clog2(STAGES + 1);

  typedef struct packed {
    logic [REG_ADDR-1:0] wreg;
    logic [WIDTH-1:0]    result;
    logic                zero;
    logic                overflow;
  } stage_t;

  logic [STAGES-1:0] valid;
  stage_t            data [STAGES];
  stage_t            head;
  logic              adv;

  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic [WIDTH-1:0]   prod_hi, prod_lo;

  // Extending both operands to 2*WIDTH lets one unsigned multiplier serve both
  // modes: the low 2*WIDTH bits of the product are identical either way.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    a_ext   = in_signed ? {{WIDTH{src1[WIDTH-1]}}, src1} : {{WIDTH{1'b0}}, src1};
    b_ext   = in_signed ? {{WIDTH{src2[WIDTH-1]}}, src2} : {{WIDTH{1'b0}}, src2};
    product = a_ext * b_ext;
    prod_hi = product[2*WIDTH-1:WIDTH];
    prod_lo = product[WIDTH-1:0];
    head.wreg     = in_wreg;
    head.result   = prod_lo;
    head.zero     = (prod_lo == '0);
    head.overflow = in_signed ? (prod_hi != {WIDTH{prod_lo[WIDTH-1]}})
                              : (prod_hi != '0);
  end

  assign adv      = !valid[STAGES-1] || out_ready;
  assign in_ready = adv;

  // NOTE: sequential state uses non-blocking assignments only. Data registers
  // are reset too, because the tail fields must read 0 while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      for (int s = 0; s < STAGES; s++) data[s] <= '0;
    end else begin
      if (adv) begin
        data[0] <= head;
        for (int s = 1; s < STAGES; s++) data[s] <= data[s-1];
      end
      // Flush wins over both hold and shift; data fields are left stale.
      if (flush)    valid <= '0;
      else if (adv) valid <= STAGES'({valid, in_valid});
    end
  end

  assign out_valid    = valid[STAGES-1];
  assign out_result   = data[STAGES-1].result;
  assign out_wreg     = data[STAGES-1].wreg;
  assign out_zero     = data[STAGES-1].zero;
  assign out_overflow = data[STAGES-1].overflow;

  logic          any1, any2;
  logic [PW-1:0] count;

  always_comb begin
    any1  = 1'b0;
    any2  = 1'b0;
    count = '0;
    for (int s = 0; s < STAGES; s++) begin
      if (valid[s] && data[s].wreg == qreg1) any1 = 1'b1;
      if (valid[s] && data[s].wreg == qreg2) any2 = 1'b1;
      count = count + PW'(valid[s]);
    end
  end

  // Register 0 is hard-wired to zero, so it can never be a real hazard.
  assign hit1    = (qreg1 != '0) && any1;
  assign hit2    = (qreg2 != '0) && any2;
  assign pending = count;

endmodule

// File: tb/tb_mul_pipe_param.sv
// Directed bench for mul_pipe_param (WIDTH=32, STAGES=5): latency, flags,
// backpressure, flush, hazard query and asynchronous reset.
module tb_mul_pipe_param;

  localparam int W  = 32;
  localparam int ST = 5;
  localparam int RA = 5;
  localparam int PW = $clog2(ST + 1);

  logic          clk, reset;
  logic          in_valid, in_ready, in_signed, flush;
  logic [W-1:0]  src1, src2;
  logic [RA-1:0] in_wreg;
  logic          out_valid, out_ready, out_zero, out_overflow;
  logic [W-1:0]  out_result;
  logic [RA-1:0] out_wreg;
  logic [RA-1:0] qreg1, qreg2;
  logic          hit1, hit2;
  logic [PW-1:0] pending;

  mul_pipe_param #(.WIDTH(W), .STAGES(ST), .REG_ADDR(RA)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .src1(src1), .src2(src2), .in_wreg(in_wreg),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_wreg(out_wreg), .out_zero(out_zero),
    .out_overflow(out_overflow), .qreg1(qreg1), .qreg2(qreg2),
    .hit1(hit1), .hit2(hit2), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [RA-1:0] wreg;
    logic          zero;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic sg, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [RA-1:0] w);
    in_valid  = v;
    in_signed = sg;
    src1      = a;
    src2      = b;
    in_wreg   = w;
  endtask

  task automatic drain(input string tag);
    set_op(1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: every retirement (tail valid and accepted) must match the
  // oldest expected result.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("retire_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("retire_result", out_result, e.res);
        check("retire_wreg", out_wreg, e.wreg);
        check("retire_zero", out_zero, e.zero);
        check("retire_ovf", out_overflow, e.ovf);
      end
    end
  end

  // Backpressure vectors: unsigned a*3, hand-computed products.
  logic [W-1:0]  bp_a   [8] = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17};
  logic [W-1:0]  bp_res [8] = '{32'h1E, 32'h21, 32'h24, 32'h27, 32'h2A, 32'h2D, 32'h30, 32'h33};

  initial begin
    int           idx, stall_left, seen;
    bit           started, found;
    logic [W-1:0] held;

    reset = 1'b0; flush = 1'b0; out_ready = 1'b1; qreg1 = '0; qreg2 = '0;
    set_op(1'b0, 1'b0, '0, '0, '0);

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_pending", pending, 0);
    check("rst_result", out_result, 0);
    check("rst_wreg", out_wreg, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    // Single signed op 7 * -3 -> r4, latency of STAGES edges
    set_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD, 5'd4);
    exp_q.push_back('{32'hFFFF_FFEB, 5'd4, 1'b0, 1'b0});
    tick();
    set_op(1'b0, 1'b0, '0, '0, '0);
    check("lat_pending1", pending, 1);
    check("lat_early_e1", out_valid, 0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("lat_early", out_valid, 0);
    end
    tick();
    check("lat_out_valid", out_valid, 1);
    check("lat_result", out_result, 32'hFFFF_FFEB);
    check("lat_wreg", out_wreg, 4);
    check("lat_zero", out_zero, 0);
    check("lat_ovf", out_overflow, 0);
    tick();
    check("lat_retired", out_valid, 0);

    // Overflow flag cases
    set_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd5);
    exp_q.push_back('{32'h0, 5'd5, 1'b1, 1'b1});
    tick();
    set_op(1'b1, 1'b1, 32'h4000_0000, 32'd2, 5'd6);
    exp_q.push_back('{32'h8000_0000, 5'd6, 1'b0, 1'b1});
    tick();
    set_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    exp_q.push_back('{32'h1, 5'd7, 1'b0, 1'b0});
    tick();
    drain("ovf_drained");

    // Backpressure: 8 back-to-back, 3 stall cycles once the first result shows
    idx = 0; stall_left = 3; started = 0; held = '0;
    for (int c = 0; c < 60; c++) begin
      if (idx >= 8 && exp_q.size() == 0) break;
      if (out_valid) started = 1;
      out_ready = !(started && stall_left > 0);
      if (idx < 8) set_op(1'b1, 1'b0, bp_a[idx], 32'd3, RA'(idx + 1));
      else         set_op(1'b0, 1'b0, '0, '0, '0);
      #1;
      if (!out_ready) begin
        check("bp_in_ready", in_ready, 0);
        if (stall_left == 3) held = out_result;
        else                 check("bp_head_stable", out_result, held);
        stall_left--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{bp_res[idx], RA'(idx + 1), 1'b0, 1'b0});
        idx++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    set_op(1'b0, 1'b0, '0, '0, '0);
    check("bp_all_issued", idx, 8);
    check("bp_stalls_done", stall_left, 0);
    check("bp_drained", exp_q.size(), 0);

    // Flush: 3 ops in flight, flush alongside a 4th issue
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, 1'b0, W'(i + 1), 32'd2, RA'(10 + i));
      tick();
    end
    set_op(1'b1, 1'b0, 32'd4, 32'd4, 5'd13);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_op(1'b0, 1'b0, '0, '0, '0);
    check("flush_pending", pending, 0);
    check("flush_out_valid", out_valid, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("flush_no_out", seen, 0);

    // Hazard query with r3 and r0 in flight
    set_op(1'b1, 1'b0, 32'd2, 32'd3, 5'd3);
    exp_q.push_back('{32'd6, 5'd3, 1'b0, 1'b0});
    tick();
    set_op(1'b1, 1'b0, 32'd4, 32'd5, 5'd0);
    exp_q.push_back('{32'd20, 5'd0, 1'b0, 1'b0});
    tick();
    set_op(1'b0, 1'b0, '0, '0, '0);
    qreg1 = 5'd3; qreg2 = 5'd0;
    #1;
    check("hz_hit1", hit1, 1);
    check("hz_hit2_r0", hit2, 0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid && out_wreg == 5'd3) begin
        tick();
        found = 1;
        break;
      end
      tick();
    end
    check("hz_r3_retired", found, 1);
    check("hz_hit1_after", hit1, 0);
    check("hz_hit2_after", hit2, 0);
    drain("hz_drained");
    qreg1 = '0;

    // Asynchronous reset with 4 ops pending
    for (int i = 0; i < 4; i++) begin
      set_op(1'b1, 1'b0, 32'd1, 32'd1, RA'(20 + i));
      tick();
    end
    set_op(1'b0, 1'b0, '0, '0, '0);
    qreg1 = 5'd20;
    #1;
    check("ar_pending4", pending, 4);
    check("ar_hit_before", hit1, 1);
    #1;
    reset = 1'b0;
    #1;
    check("ar_pending", pending, 0);
    check("ar_out_valid", out_valid, 0);
    check("ar_hit1", hit1, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_result", out_result, 0);
    check("ar_wreg", out_wreg, 0);
    check("ar_zero", out_zero, 0);
    check("ar_ovf", out_overflow, 0);
    tick();
    reset = 1'b1;
    qreg1 = '0;
    set_op(1'b1, 1'b0, 32'd9, 32'd9, 5'd9);
    #1;
    check("ar_accept_ready", in_ready, 1);
    exp_q.push_back('{32'h51, 5'd9, 1'b0, 1'b0});
    tick();
    check("ar_accepted", pending, 1);
    drain("ar_drained");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
